// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI read master among NUM_REQ requesters.
// Optional AR-stall / FIFO-full counters are enabled with `define AXI_ARB_STATS_EN.
module axi_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_BITS       = 17,
  parameter int DATA_BITS       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATA_BITS-1:0]         rsp_data,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  output logic [ADDR_BITS-1:0]         axi_araddr,
  input  logic                         axi_rvalid,
  output logic                         axi_rready,
  input  logic [DATA_BITS-1:0]         axi_rdata,
  output logic                         err_unexp_r
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  full_cnt
`endif
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  function automatic logic [ID_W-1:0] wrap_id(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

`ifdef AXI_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  state_t                 state_p0, state_d;
  logic [ID_W-1:0]        last_grant_p0;
  logic [ADDR_BITS-1:0]   araddr_p0;
  logic [ID_W-1:0]        id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_p0, rd_ptr_p0;
  logic [CNT_W-1:0]       cnt_p0;
  logic                   err_p0;

  logic                   fifo_full, fifo_empty;
  logic                   can_grant, found, grant, pop;
  logic [ID_W-1:0]        winner, cand, head;
  logic [ADDR_BITS-1:0]   addr_sel;

  assign fifo_full  = (cnt_p0 == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_p0 == '0);
  assign head       = id_mem[rd_ptr_p0];
  assign can_grant  = !fifo_full && ((state_p0 == IDLE) || axi_arready);

  // Round-robin search starting just after the previous winner
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    addr_sel = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_id(int'(last_grant_p0), k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) addr_sel = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  assign grant = !reset && can_grant && found;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (winner == ID_W'(i));
      rsp_valid[i] = !reset && !fifo_empty && axi_rvalid && (head == ID_W'(i));
    end
  end

  assign axi_rready  = !reset && !fifo_empty && rsp_ready[head];
  assign pop         = axi_rvalid && axi_rready;
  assign rsp_data    = axi_rdata;
  assign axi_arvalid = (state_p0 == ISSUE);
  assign axi_araddr  = araddr_p0;
  assign err_unexp_r = err_p0;

  always_comb begin
    state_d = state_p0;
    if (grant)                                  state_d = ISSUE;
    else if (state_p0 == ISSUE && axi_arready)  state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0      <= IDLE;
      last_grant_p0 <= ID_W'(NUM_REQ - 1);
      araddr_p0     <= '0;
      wr_ptr_p0     <= '0;
      rd_ptr_p0     <= '0;
      cnt_p0        <= '0;
      err_p0        <= 1'b0;
    end else begin
      state_p0 <= state_d;
      if (grant) begin
        last_grant_p0 <= winner;
        araddr_p0     <= addr_sel;
        wr_ptr_p0     <= wr_ptr_p0 + 1'b1;
      end
      if (pop) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({grant, pop})
        2'b10:   cnt_p0 <= cnt_p0 + 1'b1;
        2'b01:   cnt_p0 <= cnt_p0 - 1'b1;
        default: cnt_p0 <= cnt_p0;
      endcase
      if (axi_rvalid && fifo_empty) err_p0 <= 1'b1;
    end
  end

  // Tracking storage is pure data; occupancy is governed by the pointers
  always_ff @(posedge clock) begin
    if (grant) id_mem[wr_ptr_p0] <= winner;
  end

`ifdef AXI_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      full_cnt  <= '0;
    end else begin
      if (axi_arvalid && !axi_arready) stall_cnt <= sat_inc(stall_cnt);
      if (|req_valid && fifo_full)     full_cnt  <= sat_inc(full_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus a randomized
// run compared against a queue-based model of the arbitration/routing rules.
module tb_axi_read_arbiter;
  localparam int N    = 4;
  localparam int AW   = 17;
  localparam int DW   = 64;
  localparam int MAXO = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [AW-1:0]     axi_araddr;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [DW-1:0]     axi_rdata;
  logic              err_unexp_r;
`ifdef AXI_ARB_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       full_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  axi_read_arbiter #(.NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .err_unexp_r(err_unexp_r)
`ifdef AXI_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .full_cnt(full_cnt)
`endif
  );

  task automatic drive_idle();
    req_valid   = '0;
    req_addr    = '0;
    rsp_ready   = '0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (axi_arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid got %0b want 0", axi_arvalid); end
    tests++; if (axi_araddr !== '0) begin fails++; $display("FAIL reset_araddr got %0h want 0", axi_araddr); end
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    tests++; if (axi_rready !== 1'b0) begin fails++; $display("FAIL reset_rready got %0b want 0", axi_rready); end
    tests++; if (err_unexp_r !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err_unexp_r); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_rr;
    logic [AW-1:0] exp_a;
    do_reset();
    axi_arready = 1'b1;
    req_valid   = 4'b1111;
    for (int i = 0; i < N; i++) set_addr(i, AW'((i + 1) * 16));
    for (int c = 0; c < 5; c++) begin
      exp_rr = N'(1 << (c % N));
      exp_a  = AW'(((c % N) + 1) * 16);
      #1;
      tests++; if (req_ready !== exp_rr) begin fails++; $display("FAIL rr_grant%0d got %b want %b", c, req_ready, exp_rr); end
      @(negedge clock);
      tests++;
      if (axi_araddr !== exp_a || axi_arvalid !== 1'b1) begin
        fails++; $display("FAIL rr_araddr%0d got %0h/%0b want %0h/1", c, axi_araddr, axi_arvalid, exp_a);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    axi_arready = 1'b0;
    req_valid   = 4'b0001;
    set_addr(0, 17'h1ABCD);
    set_addr(1, 17'h00111);
    set_addr(2, 17'h00222);
    set_addr(3, 17'h00333);
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_first_grant got %b want 0001", req_ready); end
    @(negedge clock);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (req_ready !== 4'b0000 || axi_arvalid !== 1'b1 || axi_araddr !== 17'h1ABCD) begin
        fails++; $display("FAIL bp_hold%0d got rdy=%b v=%0b a=%0h want 0000/1/1abcd", c, req_ready, axi_arvalid, axi_araddr);
      end
      @(negedge clock);
    end
    axi_arready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_release got %b want 0010", req_ready); end
    @(negedge clock);
    req_valid = '0;
  endtask

  task automatic test_routing();
    do_reset();
    axi_arready = 1'b1;
    set_addr(2, 17'h00200);
    set_addr(1, 17'h00100);
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL route_g2 got %b want 0100", req_ready); end
    @(negedge clock);
    req_valid = 4'b0010;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL route_g1 got %b want 0010", req_ready); end
    @(negedge clock);
    req_valid  = '0;
    axi_rvalid = 1'b1;
    axi_rdata  = 64'hAA;
    rsp_ready  = 4'b0000;
    #1;
    tests++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 64'hAA || axi_rready !== 1'b0) begin
      fails++; $display("FAIL route_aa_stall got v=%b d=%0h r=%0b want 0100/aa/0", rsp_valid, rsp_data, axi_rready);
    end
    @(negedge clock);
    rsp_ready = 4'b1011;
    #1;
    tests++;
    if (rsp_valid !== 4'b0100 || axi_rready !== 1'b0) begin
      fails++; $display("FAIL route_aa_held got v=%b r=%0b want 0100/0", rsp_valid, axi_rready);
    end
    rsp_ready = 4'b0100;
    #1;
    tests++;
    if (rsp_valid !== 4'b0100 || axi_rready !== 1'b1) begin
      fails++; $display("FAIL route_aa_take got v=%b r=%0b want 0100/1", rsp_valid, axi_rready);
    end
    @(negedge clock);
    axi_rdata = 64'hBB;
    rsp_ready = 4'b0010;
    #1;
    tests++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 64'hBB || axi_rready !== 1'b1) begin
      fails++; $display("FAIL route_bb got v=%b d=%0h r=%0b want 0010/bb/1", rsp_valid, rsp_data, axi_rready);
    end
    @(negedge clock);
    axi_rvalid = 1'b0;
    #1;
    tests++;
    if (err_unexp_r !== 1'b0 || rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL route_done got err=%0b v=%b want 0/0000", err_unexp_r, rsp_valid);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    axi_arready = 1'b1;
    req_valid   = 4'b0001;
    for (int g = 0; g < MAXO; g++) begin
      set_addr(0, AW'(32'h100 + g));
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL full_fill%0d got %b want 0001", g, req_ready); end
      @(negedge clock);
    end
    set_addr(0, 17'h1FFFF);
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL full_block got %b want 0000", req_ready); end
    @(negedge clock);
    axi_rvalid = 1'b1;
    axi_rdata  = 64'h1234;
    rsp_ready  = 4'b0001;
    #1;
    tests++;
    if (axi_rready !== 1'b1 || rsp_valid !== 4'b0001 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL full_pop got r=%0b v=%b rdy=%b want 1/0001/0000", axi_rready, rsp_valid, req_ready);
    end
    @(negedge clock);
    axi_rvalid = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL full_resume got %b want 0001", req_ready); end
    @(negedge clock);
    req_valid = '0;
    tests++;
    if (axi_araddr !== 17'h1FFFF || axi_arvalid !== 1'b1) begin
      fails++; $display("FAIL full_9th_addr got %0h/%0b want 1ffff/1", axi_araddr, axi_arvalid);
    end
  endtask

  task automatic test_unexpected_r();
    do_reset();
    axi_rvalid = 1'b1;
    rsp_ready  = 4'b1111;
    #1;
    tests++;
    if (axi_rready !== 1'b0 || rsp_valid !== 4'b0000 || err_unexp_r !== 1'b0) begin
      fails++; $display("FAIL unexp_same got r=%0b v=%b e=%0b want 0/0000/0", axi_rready, rsp_valid, err_unexp_r);
    end
    @(negedge clock);
    axi_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (err_unexp_r !== 1'b1) begin fails++; $display("FAIL unexp_sticky%0d got %0b want 1", c, err_unexp_r); end
      @(negedge clock);
    end
    do_reset();
    #1;
    tests++; if (err_unexp_r !== 1'b0) begin fails++; $display("FAIL unexp_clear got %0b want 0", err_unexp_r); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    axi_arready = 1'b1;
    req_valid   = 4'b1111;
    for (int i = 0; i < N; i++) set_addr(i, AW'(32'h400 + i));
    repeat (3) @(negedge clock);
    axi_arready = 1'b0;
    #1;
    tests++; if (axi_arvalid !== 1'b1) begin fails++; $display("FAIL mid_pre_arvalid got %0b want 1", axi_arvalid); end
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    req_valid = '0;
    #1;
    tests++; if (axi_arvalid !== 1'b0) begin fails++; $display("FAIL mid_arvalid got %0b want 0", axi_arvalid); end
    axi_rvalid = 1'b1;
    rsp_ready  = 4'b1111;
    #1;
    tests++;
    if (rsp_valid !== 4'b0000 || axi_rready !== 1'b0) begin
      fails++; $display("FAIL mid_fifo_empty got v=%b r=%0b want 0000/0", rsp_valid, axi_rready);
    end
    axi_rvalid  = 1'b0;
    req_valid   = 4'b1111;
    axi_arready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_priority got %b want 0001", req_ready); end
    @(negedge clock);
    req_valid = '0;
  endtask

  task automatic test_random();
    int            lg;
    int            q[$];
    bit            m_arv;
    bit            m_err;
    logic [AW-1:0] m_ara;
    logic [AW-1:0] a [N];
    int            win;
    logic [N-1:0]  e_rr, e_rv;
    logic          e_rdy;
    bit            busy_phase;
    do_reset();
    lg = N - 1; q.delete(); m_arv = 0; m_err = 0; m_ara = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      busy_phase = ((cyc / 150) % 2) == 1;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i] = AW'($urandom);
        set_addr(i, a[i]);
      end
      axi_arready = ($urandom_range(0, 3) != 0);
      axi_rvalid  = busy_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rsp_ready   = N'($urandom) | N'($urandom);
      axi_rdata   = {$urandom, $urandom};
      #1;
      win = -1;
      if (q.size() < MAXO && (!m_arv || axi_arready))
        for (int k = 1; k <= N; k++)
          if (win < 0 && req_valid[(lg + k) % N]) win = (lg + k) % N;
      e_rr  = (win >= 0) ? N'(1 << win) : '0;
      e_rv  = '0;
      e_rdy = 1'b0;
      if (q.size() > 0) begin
        e_rv  = axi_rvalid ? N'(1 << q[0]) : '0;
        e_rdy = rsp_ready[q[0]];
      end
      tests++;
      if (axi_arvalid !== m_arv || (m_arv && axi_araddr !== m_ara) || err_unexp_r !== m_err) begin
        fails++; $display("FAIL rnd_state c%0d got v=%0b a=%0h e=%0b want v=%0b a=%0h e=%0b",
                          cyc, axi_arvalid, axi_araddr, err_unexp_r, m_arv, m_ara, m_err);
      end
      tests++;
      if (req_ready !== e_rr) begin fails++; $display("FAIL rnd_grant c%0d got %b want %b", cyc, req_ready, e_rr); end
      tests++;
      if (rsp_valid !== e_rv || axi_rready !== e_rdy || rsp_data !== axi_rdata) begin
        fails++; $display("FAIL rnd_rsp c%0d got v=%b r=%0b want v=%b r=%0b", cyc, rsp_valid, axi_rready, e_rv, e_rdy);
      end
      if (q.size() == 0 && axi_rvalid) m_err = 1;
      if (q.size() > 0 && axi_rvalid && e_rdy) void'(q.pop_front());
      if (win >= 0) begin
        q.push_back(win);
        m_ara = a[win];
        m_arv = 1;
        lg    = win;
      end else if (m_arv && axi_arready) begin
        m_arv = 0;
      end
      @(negedge clock);
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_routing();
    test_fifo_full();
    test_unexpected_r();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
